// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined CPU front end.
//   - PCSRC_* : decode's next-PC source select codes (pcsource).
//   - SELPC_* : interrupt/eret override select codes (selpc).
//   - *_DEF   : default reset PC, exception vector and bubble word.
//   - fetch_state_t : instruction-fetch FSM state encoding.
// Optional feature macro: IF_FLUSH_EN adds the DISCARD fetch state.
package cpu_pkg;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_BPC  = 2'b01;
    localparam logic [1:0] PCSRC_JPC  = 2'b10;
    localparam logic [1:0] PCSRC_JPC2 = 2'b11;

    localparam logic [1:0] SELPC_PCSRC = 2'b00;
    localparam logic [1:0] SELPC_EPC   = 2'b01;
    localparam logic [1:0] SELPC_EXC   = 2'b10;
    localparam logic [1:0] SELPC_EXC2  = 2'b11;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0008;
    localparam logic [31:0] NOP_WORD_DEF   = 32'h0000_0000;

`ifdef IF_FLUSH_EN
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HELD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HELD  = 2'd1
    } fetch_state_t;
`endif

endpackage

// File: rtl/npc_sel.sv
// Combinational next-PC selection.
//   pc        : current fetch PC
//   pcsource  : 00 pc+4, 01 bpc, 10/11 jpc
//   selpc     : 00 use pcsource, 01 epc, 10/11 EXC_VECTOR
//   bpc/jpc/epc : candidate targets from decode
//   pend/pend_pc: a retained redirect, which overrides everything
//   tgt       : redirect target selected this cycle
//   redir     : a redirect is requested this cycle
//   npc       : next PC (32-bit wrap)
module npc_sel
    import cpu_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic [1:0]  selpc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] epc,
    input  logic        pend,
    input  logic [31:0] pend_pc,
    output logic [31:0] tgt,
    output logic        redir,
    output logic [31:0] npc
);

    logic [31:0] pc_plus4;
    logic [31:0] src_pc;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        src_pc = pc_plus4;
        case (pcsource)
            PCSRC_PC4:  src_pc = pc_plus4;
            PCSRC_BPC:  src_pc = bpc;
            PCSRC_JPC:  src_pc = jpc;
            PCSRC_JPC2: src_pc = jpc;
            default:    src_pc = pc_plus4;
        endcase
    end

    always_comb begin
        tgt = src_pc;
        case (selpc)
            SELPC_PCSRC: tgt = src_pc;
            SELPC_EPC:   tgt = epc;
            SELPC_EXC:   tgt = EXC_VECTOR;
            SELPC_EXC2:  tgt = EXC_VECTOR;
            default:     tgt = src_pc;
        endcase
    end

    assign redir = (selpc != SELPC_PCSRC) || (pcsource != PCSRC_PC4);

    always_comb begin
        npc = pc_plus4;
        if (pend)
            npc = pend_pc;
        else if (redir)
            npc = tgt;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction
// memory port and holds the IF/ID pipeline register feeding decode.
//   clk, rst        : clock, synchronous active-high reset
//   stall           : decode load-use stall, freezes PC and IF/ID
//   pcsource, selpc : next-PC selects from decode
//   bpc, jpc, epc   : branch, jump and EPC targets
//   imem_req/addr   : fetch request and address (current PC)
//   imem_ack/rdata  : read data valid and instruction word
//   npc             : combinational next PC (saved to EPC on interrupt)
//   id_pc, pc4, inst, id_valid : IF/ID register contents
// Optional feature macro: IF_FLUSH_EN -- an exception squashes the
// instruction being fetched instead of letting it run as a delay slot.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [1:0]  pcsource,
    input  logic [1:0]  selpc,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] epc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] npc,
    output logic [31:0] id_pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        id_valid
);

    fetch_state_t state, state_next;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pend;
    logic [31:0] pend_pc;
    logic [31:0] buffer;
    logic [31:0] tgt;
    logic        redir;
    logic        fc;
    logic        flush;
    logic [31:0] fetched_word;

    npc_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_npc_sel (
        .pc       (pc),
        .pcsource (pcsource),
        .selpc    (selpc),
        .bpc      (bpc),
        .jpc      (jpc),
        .epc      (epc),
        .pend     (pend),
        .pend_pc  (pend_pc),
        .tgt      (tgt),
        .redir    (redir),
        .npc      (npc)
    );

    assign pc_plus4     = pc + 32'd4;
    assign imem_addr    = pc;
    assign imem_req     = !rst && (state == FETCH);
    assign fc           = ((state == FETCH) && imem_ack) || (state == HELD);
    assign fetched_word = (state == HELD) ? buffer : imem_rdata;

`ifdef IF_FLUSH_EN
    assign flush = !stall && selpc[1];
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (imem_ack && stall)
                    state_next = HELD;
`ifdef IF_FLUSH_EN
                // An un-acked fetch squashed by an exception still owes
                // one ack, which must not be taken as the vector's word.
                else if (flush && !imem_ack)
                    state_next = DISCARD;
`endif
                else
                    state_next = FETCH;
            end
            HELD: begin
                if (!stall)
                    state_next = FETCH;
            end
`ifdef IF_FLUSH_EN
            DISCARD: begin
                if (imem_ack)
                    state_next = FETCH;
            end
`endif
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            id_pc    <= '0;
            pc4      <= '0;
            inst     <= NOP_WORD;
            id_valid <= 1'b0;
            pend     <= 1'b0;
            pend_pc  <= '0;
            buffer   <= NOP_WORD;
        end else begin
            // Ack arriving under stall is parked until decode releases.
            if ((state == FETCH) && imem_ack && stall)
                buffer <= imem_rdata;

            if (!stall) begin
                if (flush) begin
                    inst     <= NOP_WORD;
                    id_valid <= 1'b0;
                    pc       <= EXC_VECTOR;
                    pend     <= 1'b0;
                end else if (fc) begin
                    id_pc    <= pc;
                    pc4      <= pc_plus4;
                    inst     <= fetched_word;
                    id_valid <= 1'b1;
                    pc       <= npc;
                    pend     <= 1'b0;
                end else begin
                    inst     <= NOP_WORD;
                    id_valid <= 1'b0;
                    // First redirect seen during a wait is retained;
                    // later ones are dropped until it is applied.
                    if (redir && !pend) begin
                        pend    <= 1'b1;
                        pend_pc <= tgt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  pcsource;
    logic [1:0]  selpc;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] epc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] npc;
    logic [31:0] id_pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        id_valid;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    // Memory image: word at address A is 0x20010000 + A/4 + 1.
    assign imem_rdata = 32'h2001_0000 + (imem_addr >> 2) + 32'd1;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .pcsource   (pcsource),
        .selpc      (selpc),
        .bpc        (bpc),
        .jpc        (jpc),
        .epc        (epc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .npc        (npc),
        .id_pc      (id_pc),
        .pc4        (pc4),
        .inst       (inst),
        .id_valid   (id_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_inst,
                            input logic e_valid);
        chk({tag, ".id_pc"}, id_pc, e_pc);
        chk({tag, ".inst"}, inst, e_inst);
        chk({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, e_valid});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pcsource = 2'b00; selpc = 2'b00;
        bpc = '0; jpc = '0; epc = '0; imem_ack = 1'b0;
        tick();
        tick();
        // Reset state
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        chk("rst.pc4", pc4, 32'h0);

        // Zero-wait run
        rst = 1'b0; imem_ack = 1'b1;
        #1;
        chk("zw.req", {31'd0, imem_req}, 32'd1);
        chk("zw.npc0", npc, 32'h4);
        tick();
        chk_ifid("zw0", 32'h0, 32'h2001_0001, 1'b1);
        chk("zw0.pc4", pc4, 32'h4);
        tick();
        chk_ifid("zw1", 32'h4, 32'h2001_0002, 1'b1);
        chk("zw1.pc4", pc4, 32'h8);
        tick();
        chk_ifid("zw2", 32'h8, 32'h2001_0003, 1'b1);
        chk("zw2.pc4", pc4, 32'hc);
        chk("zw2.addr", imem_addr, 32'hc);
        tick();
        chk("zw3.addr", imem_addr, 32'h10);

        // Two wait cycles at 0x10
        imem_ack = 1'b0;
        tick();
        chk_ifid("ws0", 32'hc, 32'h0, 1'b0);
        chk("ws0.addr", imem_addr, 32'h10);
        tick();
        chk_ifid("ws1", 32'hc, 32'h0, 1'b0);
        imem_ack = 1'b1;
        tick();
        chk_ifid("ws2", 32'h10, 32'h2001_0005, 1'b1);
        chk("ws2.addr", imem_addr, 32'h14);

        // Stall for 3 cycles, ack in the first
        stall = 1'b1;
        tick();
        chk_ifid("st0", 32'h10, 32'h2001_0005, 1'b1);
        chk("st0.req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        tick();
        chk("st1.req", {31'd0, imem_req}, 32'd0);
        tick();
        chk_ifid("st2", 32'h10, 32'h2001_0005, 1'b1);
        chk("st2.addr", imem_addr, 32'h14);
        stall = 1'b0;
        tick();
        chk_ifid("st3", 32'h14, 32'h2001_0006, 1'b1);
        chk("st3.addr", imem_addr, 32'h18);
        chk("st3.req", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1;
        tick();
        tick();
        chk("pre_br.addr", imem_addr, 32'h20);

        // Branch during wait; a second redirect is ignored
        imem_ack = 1'b0; pcsource = 2'b01; bpc = 32'h100;
        tick();
        chk_ifid("br0", 32'h1c, 32'h0, 1'b0);
        pcsource = 2'b10; jpc = 32'h200;
        #1;
        chk("br0.npc", npc, 32'h100);
        tick();
        pcsource = 2'b00;
        #1;
        chk("br1.npc", npc, 32'h100);
        imem_ack = 1'b1;
        tick();
        chk_ifid("br2", 32'h20, 32'h2001_0009, 1'b1);
        chk("br2.addr", imem_addr, 32'h100);

        // Jump to 0x40, then interrupt there
        pcsource = 2'b10; jpc = 32'h40;
        tick();
        chk("jmp.addr", imem_addr, 32'h40);
        pcsource = 2'b00; selpc = 2'b10;
        #1;
        chk("irq.npc", npc, 32'h8);
        tick();
`ifdef IF_FLUSH_EN
        chk_ifid("irq", 32'h100, 32'h0, 1'b0);
`else
        chk_ifid("irq", 32'h40, 32'h2001_0011, 1'b1);
`endif
        chk("irq.addr", imem_addr, 32'h8);

        // Eret
        selpc = 2'b01; epc = 32'h44;
        #1;
        chk("eret.npc", npc, 32'h44);
        tick();
        chk("eret.addr", imem_addr, 32'h44);
        selpc = 2'b00;

        // Reset during a wait
        imem_ack = 1'b0;
        tick();
        chk("rw.valid", {31'd0, id_valid}, 32'd0);
        rst = 1'b1;
        tick();
        chk("rw.addr", imem_addr, 32'h0);
        chk("rw.req", {31'd0, imem_req}, 32'd0);
        chk_ifid("rw", 32'h0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage interrupt-capable pipeline, directly upstream of the decode stage.
- Owns the PC register and selects the next PC from PC+4, branch target, jump target, EPC or the exception vector.
- Drives a req/ack instruction-memory interface and holds the IF/ID pipeline register that feeds decode with pc, pc4, npc and the instruction word.
- Inserts NOP bubbles on memory wait states, holds under stall, and retains redirects that arrive while a fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0008, interrupt/exception handler entry.
- NOP_WORD, 32'h0000_0000, bubble instruction (sll $0,$0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  decode load-use stall; freezes PC and IF/ID.
- pcsource  in  2  00 pc+4, 01 bpc, 10 jpc, 11 jpc.
- selpc  in  2  00 use pcsource, 01 epc (eret), 10/11 EXC_VECTOR.
- bpc  in  32  branch target from decode.
- jpc  in  32  jump/jr target from decode.
- epc  in  32  EPC register value from decode.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (current PC).
- imem_ack  in  1  read data valid this cycle; may coincide with req (zero-wait).
- imem_rdata  in  32  instruction word.
- npc  out  32  combinational next PC; decode saves it into EPC on interrupt.
- id_pc  out  32  registered PC of the instruction in decode.
- pc4  out  32  registered id_pc+4.
- inst  out  32  registered instruction word.
- id_valid  out  1  registered; 0 when inst is a bubble.

Behaviour:
- Reset: pc=RESET_PC; id_pc=0; pc4=0; inst=NOP_WORD; id_valid=0; pend=0; state=FETCH; imem_req forced 0 while rst=1.
- States: FETCH (req=1, addr=pc), HELD (req=0, instruction buffered).
- Fetch complete (fc): (FETCH & imem_ack) | HELD.
- Redirect target: tgt = selpc!=00 ? (selpc==01 ? epc : EXC_VECTOR) : pcsource mux; redir = (selpc!=00) | (pcsource!=00).
- npc = pend ? pend_pc : (redir ? tgt : pc+4), 32-bit wrap.
- fc & !stall:
  - IF/ID <= {pc, pc+4, word, valid=1}, where word is the buffer in HELD, otherwise imem_rdata.
  - pc <= npc; pend <= 0; state <= FETCH.
  - Delayed-branch semantics: the instruction fetched in the same cycle as the redirect is the delay slot.
- !fc & !stall:
  - IF/ID loads a bubble (inst=NOP_WORD, valid=0, id_pc/pc4 unchanged).
  - pc holds.
  - If redir & !pend: pend<=1, pend_pc<=tgt. The first redirect wins; later ones are ignored until applied.
- stall:
  - IF/ID, pc and pend hold; redir is ignored because decode re-presents it.
  - FETCH & imem_ack & stall: buffer<=imem_rdata, state<=HELD.
- Latency: zero-wait memory sustains 1 instruction/cycle; each wait cycle inserts exactly one bubble.
- Reset mid-fetch: request dropped; a later ack is ignored because req=0.

Optional Feature:
- IF_FLUSH_EN defined:
  - selpc[1]=1 (exception) with !stall forces a bubble into IF/ID this cycle, with no delay slot.
  - pc <= EXC_VECTOR immediately; pend cleared.
  - In FETCH without ack, state goes to DISCARD (req=0), which swallows one ack, then returns to FETCH.
  - HELD is discarded.
- IF_FLUSH_EN undefined: exceptions follow the delay-slot rule above; DISCARD state does not exist.

Decomposition:
- Shared package cpu_pkg: PCSRC_* and SELPC_* codes, RESET_PC/EXC_VECTOR defaults, NOP_WORD, fetch-state enum.
- One sub-module, npc_sel (combinational next-PC mux with pend override), reused by branch-prediction work later.

Test Plan:
- Zero-wait run: ack tied 1, words 0x20010001… at 0,4,8 → inst changes each cycle; id_pc 0,4,8; pc4 4,8,12; id_valid=1.
- Wait states: ack low 2 cycles at pc=0x10 → two bubbles (inst=0, id_valid=0); then inst=word@0x10 and pc=0x14.
- Stall with ack: stall=1 for 3 cycles while ack arrives in cycle 1 → IF/ID frozen, state HELD, req=0; after release, buffered word enters decode and pc advances by 4.
- Branch during wait: pcsource=01, bpc=0x100 while fetch at 0x20 un-acked → pend set; on ack, 0x20 delay slot enters decode and the next imem_addr=0x100.
- Interrupt: selpc=10 at pc=0x40 with ack=1 → npc=0x8; delay slot 0x40 enters decode and the next addr=0x8. With IF_FLUSH_EN: bubble enters decode and the next addr=0x8.
- Eret and reset: selpc=01, epc=0x44 → next addr=0x44. rst asserted mid-wait → pc=0, req=0, inst=0, id_valid=0 on the next edge.
